// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: holds the PC, issues one-outstanding reads to
// instruction memory and hands each instruction to decode over valid/ready.
module fetch_unit #(
    parameter int             N        = 64,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_src,
    input  logic [N-1:0]  branch_target,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [N-1:0]  pc_out,
    output logic [10:0]   op
);

    // state | meaning
    // IDLE  | one cycle after reset before the first request
    // FETCH | imem_req high, waiting for memory to accept PC
    // WAIT  | request accepted, waiting for read data
    // HOLD  | instruction presented to decode, waiting for instr_ready
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  pc, pc_nxt;
    logic [N-1:0]  pc_req, pc_req_nxt;
    logic [N-1:0]  pc_out_nxt;
    logic [N-1:0]  target;
    logic [31:0]   instr_nxt;
    logic          drop, drop_nxt;
    logic          valid_nxt;

    assign target    = {branch_target[N-1:2], 2'b00};
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign op        = instr[31:21];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pc_req      <= '0;
            drop        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc_out      <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pc_req      <= pc_req_nxt;
            drop        <= drop_nxt;
            instr_valid <= valid_nxt;
            instr       <= instr_nxt;
            pc_out      <= pc_out_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_src ? target : pc;
        pc_req_nxt = pc_req;
        drop_nxt   = drop;
        valid_nxt  = instr_valid;
        instr_nxt  = instr;
        pc_out_nxt = pc_out;

        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    pc_req_nxt = pc;
                    state_nxt  = WAIT;
                    // a redirect in the accept cycle still sends the old address; its data is stale
                    drop_nxt   = pc_src;
                    if (!pc_src)
                        pc_nxt = pc + N'(4);
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    drop_nxt = 1'b0;
                    if (drop || pc_src) begin
                        state_nxt = FETCH;
                    end else begin
                        instr_nxt  = imem_rdata;
                        pc_out_nxt = pc_req;
                        valid_nxt  = 1'b1;
                        state_nxt  = HOLD;
                    end
                end else if (pc_src) begin
                    drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (pc_src || instr_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
